// File: rtl/mac_t_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mac_t_framer
//
// Transmit framer for the switch egress MAC path. Pops one frame descriptor
// from the output queue, prefetches its payload from the data FIFO and emits a
// complete 802.3 frame as a byte stream:
//   preamble (0x55 x PRE_LEN), SFD (0xD5), payload, zero pad up to MIN_LEN,
//   FCS (~CRC-32, LSB byte first), then IFG_LEN idle cycles.
// When the descriptor flags fcs_present, the payload already carries its FCS,
// so no pad or FCS is appended.
//
// Ports
//   clk, rstn         : clock, asynchronous active-low reset
//   ptr_fifo_empty    : descriptor FIFO empty
//   ptr_fifo_din      : show-ahead descriptor {fcs_present, -, len[LEN_W-1:0]}
//   ptr_fifo_rd       : one-cycle descriptor pop
//   data_fifo_rd      : payload byte read request
//   data_fifo_din     : payload byte, valid the cycle after data_fifo_rd
//   tx_valid/tx_ready : output byte handshake
//   tx_data           : output byte
//   tx_sof / tx_eof   : first preamble byte / last frame byte
//   frame_cnt         : completed frames (wraps)
//   drop_cnt          : discarded zero-length descriptors (wraps)
// -----------------------------------------------------------------------------
module mac_t_framer #(
   parameter int PRE_LEN = 7,
   parameter int MIN_LEN = 60,
   parameter int IFG_LEN = 12,
   parameter int LEN_W   = 11
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ptr_fifo_empty,
   input  logic [15:0] ptr_fifo_din,
   output logic        ptr_fifo_rd,
   output logic        data_fifo_rd,
   input  logic [7:0]  data_fifo_din,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_sof,
   output logic        tx_eof,
   input  logic        tx_ready,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [31:0]      CRC_POLY = 32'hEDB88320;
   localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
   localparam logic [15:0]      PRE_LAST = 16'(PRE_LEN - 1);
   localparam logic [15:0]      IFG_LAST = 16'((IFG_LEN > 0) ? IFG_LEN - 1 : 0);
   localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   // Reflected CRC-32, one byte per call.
   function automatic logic [31:0] crc32_upd(input logic [31:0] crc,
                                             input logic [7:0]  d);
      logic [31:0] c;
      c = crc ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t           state_q, state_d;
   logic             en_q, en_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] pad_q, pad_d;
   logic [LEN_W-1:0] req_q, req_d;
   logic             fcs_q, fcs_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [31:0]      crc_q, crc_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             rd_q, rd_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       fill_q, fill_d;
   logic [7:0]       buf_q [2];
   logic [7:0]       buf_d [2];

   logic [LEN_W-1:0] desc_len;
   logic             desc_fcs;
   logic [15:0]      len_m1;
   logic [15:0]      pad_m1;
   logic             pop;
   logic [2:0]       lvl;

   assign desc_len = ptr_fifo_din[LEN_W-1:0];
   assign desc_fcs = ptr_fifo_din[15];
   assign len_m1   = 16'(len_q) - 16'd1;
   assign pad_m1   = 16'(pad_q) - 16'd1;

   generate
      if (LEN_W < 15) begin : g_desc_spare
         logic unused_desc_bits;
         assign unused_desc_bits = ^ptr_fifo_din[14:LEN_W];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      en_d         = 1'b1;
      len_d        = len_q;
      fcs_d        = fcs_q;
      pad_d        = pad_q;
      req_d        = req_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      frame_cnt_d  = frame_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      rd_d         = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fill_d       = fill_q;
      buf_d        = buf_q;
      ptr_fifo_rd  = 1'b0;
      data_fifo_rd = 1'b0;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      tx_sof       = 1'b0;
      tx_eof       = 1'b0;
      pop          = 1'b0;
      lvl          = 3'd0;

      case (state_q)
         S_IDLE: begin
            // en_q keeps the pop quiet during and right after reset.
            if (en_q && !ptr_fifo_empty) begin
               ptr_fifo_rd = 1'b1;
               len_d       = desc_len;
               fcs_d       = desc_fcs;
               if (desc_len == '0) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end else begin
                  if (desc_fcs || (desc_len >= MIN_L)) pad_d = '0;
                  else                                 pad_d = MIN_L - desc_len;
                  crc_d   = CRC_INIT;
                  cnt_d   = 16'd0;
                  req_d   = '0;
                  state_d = S_PRE;
               end
            end
         end

         S_PRE: begin
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            tx_sof   = (cnt_q == 16'd0);
            if (tx_ready) begin
               if (cnt_q == PRE_LAST) begin
                  cnt_d   = 16'd0;
                  state_d = S_SFD;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end

         S_SFD: begin
            tx_valid = 1'b1;
            tx_data  = 8'hD5;
            if (tx_ready) begin
               cnt_d   = 16'd0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = buf_q[rd_ptr_q];
            tx_eof   = fcs_q && (cnt_q == len_m1);
            if (tx_ready) begin
               pop   = 1'b1;
               crc_d = crc32_upd(crc_q, buf_q[rd_ptr_q]);
               if (cnt_q == len_m1) begin
                  cnt_d = 16'd0;
                  if (fcs_q) begin
                     state_d     = S_IFG;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                  end else if (pad_q != '0) begin
                     state_d = S_PAD;
                  end else begin
                     state_d = S_FCS;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end

         S_PAD: begin
            tx_valid = 1'b1;
            tx_data  = 8'h00;
            if (tx_ready) begin
               crc_d = crc32_upd(crc_q, 8'h00);
               if (cnt_q == pad_m1) begin
                  cnt_d   = 16'd0;
                  state_d = S_FCS;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end

         S_FCS: begin
            // crc_q is frozen here, so the byte stays stable under stall.
            tx_valid = 1'b1;
            tx_data  = ~crc_q[8*cnt_q[1:0] +: 8];
            tx_eof   = (cnt_q[1:0] == 2'd3);
            if (tx_ready) begin
               if (cnt_q[1:0] == 2'd3) begin
                  cnt_d       = 16'd0;
                  state_d     = S_IFG;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end

         S_IFG: begin
            if (cnt_q == IFG_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Prefetch: occupancy is counted after this cycle's pop so a read can
      // be issued every cycle in steady state despite the one-cycle read
      // latency, which keeps DATA bubble-free with only two entries.
      lvl = {1'b0, fill_q} + {2'b00, rd_q} - {2'b00, pop};
      if (((state_q == S_PRE) || (state_q == S_SFD) || (state_q == S_DATA)) &&
          (lvl < 3'd2) && (req_q < len_q)) begin
         data_fifo_rd = 1'b1;
         req_d        = req_q + LEN_W'(1);
      end
      rd_d = data_fifo_rd;

      if (rd_q) begin
         buf_d[wr_ptr_q] = data_fifo_din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      fill_d = fill_q + {1'b0, rd_q} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         en_q        <= 1'b0;
         len_q       <= '0;
         fcs_q       <= 1'b0;
         pad_q       <= '0;
         req_q       <= '0;
         cnt_q       <= 16'd0;
         crc_q       <= CRC_INIT;
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
         rd_q        <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fill_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         len_q       <= len_d;
         fcs_q       <= fcs_d;
         pad_q       <= pad_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         crc_q       <= crc_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         rd_q        <= rd_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
      end
   end

   // Payload storage needs no reset: fill_q says which entries are live.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mac_t_framer.sv
`timescale 1ns/1ps
module tb_mac_t_framer;

   localparam int PRE_LEN = 7;
   localparam int MIN_LEN = 60;
   localparam int IFG_LEN = 12;
   localparam int LEN_W   = 11;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ptr_fifo_empty;
   logic [15:0] ptr_fifo_din;
   logic        ptr_fifo_rd;
   logic        data_fifo_rd;
   logic [7:0]  data_fifo_din;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_sof;
   logic        tx_eof;
   logic        tx_ready;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   mac_t_framer #(
      .PRE_LEN(PRE_LEN),
      .MIN_LEN(MIN_LEN),
      .IFG_LEN(IFG_LEN),
      .LEN_W  (LEN_W)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .ptr_fifo_empty(ptr_fifo_empty),
      .ptr_fifo_din  (ptr_fifo_din),
      .ptr_fifo_rd   (ptr_fifo_rd),
      .data_fifo_rd  (data_fifo_rd),
      .data_fifo_din (data_fifo_din),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_sof        (tx_sof),
      .tx_eof        (tx_eof),
      .tx_ready      (tx_ready),
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Upstream queues and the scoreboard of expected {sof, eof, byte}.
   logic [15:0] ptr_q [$];
   logic [7:0]  data_q [$];
   logic [9:0]  exp_q [$];

   bit   rand_ready = 1'b0;
   bit   s_prd = 1'b0, s_drd = 1'b0;
   int   cyc = 0, rd_cnt = 0;
   int   pop_cyc = 0, sof_cyc = 0, eof_cyc = 0;
   int   last_gap = 0, frm_bytes = 0, last_frm_bytes = 0, last_span = 0;
   bit   prev_stall = 1'b0;
   logic [9:0] prev_out = '0;

   // Bit-serial reference CRC-32 (reflected).
   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[31:1]};
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   // kind 0: ASCII '1','2',...; kind 1: random bytes.
   task automatic push_frame(input int len, input bit fcs, input int kind);
      logic [7:0]  b;
      logic [31:0] crc;
      int          body;
      ptr_q.push_back({fcs, 4'b0000, 11'(len)});
      if (len == 0) return;
      for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({(i == 0), 1'b0, 8'h55});
      exp_q.push_back({2'b00, 8'hD5});
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < len; i++) begin
         b = (kind == 0) ? 8'(8'h31 + i) : 8'($urandom);
         data_q.push_back(b);
         crc = ref_crc(crc, b);
         exp_q.push_back({1'b0, (fcs && (i == len - 1)), b});
      end
      if (!fcs) begin
         body = (len < MIN_LEN) ? MIN_LEN : len;
         for (int i = len; i < body; i++) begin
            crc = ref_crc(crc, 8'h00);
            exp_q.push_back({2'b00, 8'h00});
         end
         crc = ~crc;
         for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (k == 3), crc[8*k +: 8]});
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      repeat (IFG_LEN + 4) @(negedge clk);
   endtask

   // Upstream FIFO model, tx_ready driver and output monitor.
   initial begin
      logic [9:0]  e;
      logic [15:0] dummy16;
      ptr_fifo_empty = 1'b1;
      ptr_fifo_din   = 16'h0000;
      data_fifo_din  = 8'h00;
      tx_ready       = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rstn) begin
            if (s_prd && ptr_q.size() > 0) dummy16 = ptr_q.pop_front();
            if (s_drd) begin
               if (data_q.size() > 0) data_fifo_din = data_q.pop_front();
               else check("over_read", 32'd1, 32'd0);
            end
         end
         ptr_fifo_empty = (ptr_q.size() == 0);
         ptr_fifo_din   = (ptr_q.size() == 0) ? 16'h0000 : ptr_q[0];
         tx_ready       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         cyc++;
         s_prd = ptr_fifo_rd;
         s_drd = data_fifo_rd;
         if (!rstn) begin
            prev_stall = 1'b0;
            continue;
         end
         if (ptr_fifo_rd)  pop_cyc = cyc;
         if (data_fifo_rd) rd_cnt++;
         if (prev_stall) check("stall_hold", 32'({tx_valid, tx_sof, tx_eof, tx_data}), 32'({1'b1, prev_out}));
         if (tx_valid && tx_ready) begin
            if (tx_sof) begin
               sof_cyc   = cyc;
               last_gap  = cyc - eof_cyc - 1;
               frm_bytes = 0;
            end
            frm_bytes++;
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'({tx_sof, tx_eof, tx_data}), 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               check("byte", 32'({tx_sof, tx_eof, tx_data}), 32'(e));
            end
            if (tx_eof) begin
               eof_cyc        = cyc;
               last_frm_bytes = frm_bytes;
               last_span      = cyc - sof_cyc + 1;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_out   = {tx_sof, tx_eof, tx_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a descriptor already waiting: nothing may be popped.
      push_frame(9, 1'b1, 0);
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({tx_valid, tx_sof, tx_eof, ptr_fifo_rd, data_fifo_rd, tx_data}), 32'd0);
      check("rst_cnts", {frame_cnt, drop_cnt}, 32'd0);
      rstn = 1'b1;

      // "123456789" with FCS already present: 17 bytes back to back.
      wait_done("t1", 200);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t1_bytes", 32'(last_frm_bytes), 32'd17);
      check("t1_span", 32'(last_span), 32'd17);
      check("t1_pop_to_sof", 32'(sof_cyc - pop_cyc), 32'd1);

      // 60-byte payload: no pad, FCS appended.
      push_frame(60, 1'b0, 1);
      wait_done("t2", 400);
      check("t2_bytes", 32'(last_frm_bytes), 32'd72);
      check("t2_span", 32'(last_span), 32'd72);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

      // 14-byte payload: 46 pad bytes.
      push_frame(14, 1'b0, 1);
      wait_done("t3", 400);
      check("t3_bytes", 32'(last_frm_bytes), 32'd72);
      check("t3_span", 32'(last_span), 32'd72);

      // 100-byte frame under random backpressure.
      rd_cnt     = 0;
      rand_ready = 1'b1;
      push_frame(100, 1'b0, 1);
      wait_done("t4", 3000);
      rand_ready = 1'b0;
      check("t4_rd_cnt", 32'(rd_cnt), 32'd100);
      check("t4_bytes", 32'(last_frm_bytes), 32'd112);
      check("t4_frame_cnt", 32'(frame_cnt), 32'd4);

      // Back-to-back descriptors: IFG plus the pop cycle between frames.
      push_frame(20, 1'b0, 1);
      push_frame(20, 1'b0, 1);
      wait_done("t5", 600);
      check("t5_gap", 32'(last_gap), 32'(IFG_LEN + 1));
      check("t5_frame_cnt", 32'(frame_cnt), 32'd6);
      check("t5_drop_cnt", 32'(drop_cnt), 32'd0);

      // Zero-length descriptor in between costs one extra pop cycle only.
      push_frame(20, 1'b0, 1);
      push_frame(0, 1'b0, 1);
      push_frame(25, 1'b1, 1);
      wait_done("t6", 600);
      check("t6_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t6_gap", 32'(last_gap), 32'(IFG_LEN + 2));
      check("t6_frame_cnt", 32'(frame_cnt), 32'd8);

      // Reset in the middle of DATA, then a clean frame.
      frm_bytes = 0;
      push_frame(40, 1'b0, 1);
      for (int i = 0; i < 300 && frm_bytes < PRE_LEN + 1 + 5; i++) @(negedge clk);
      check("t7_reached_data", 32'(frm_bytes >= PRE_LEN + 1 + 5), 32'd1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("t7_async_outs", 32'({tx_valid, tx_sof, tx_eof, ptr_fifo_rd, data_fifo_rd, tx_data}), 32'd0);
      check("t7_async_cnts", {frame_cnt, drop_cnt}, 32'd0);
      repeat (2) @(negedge clk);
      ptr_q.delete();
      data_q.delete();
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      push_frame(30, 1'b0, 1);
      wait_done("t7", 400);
      check("t7_bytes", 32'(last_frm_bytes), 32'd72);
      check("t7_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
